// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: NUM_CH producer channels in, one consumer channel out.
// The slave modport is the mux's view; the master modport is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_last;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with registered output, fixed-select or round-robin arbitration.
// Define STREAM_MUX_PKT_LOCK_EN to keep a channel granted until its in_last beat is accepted.
module stream_mux_rr #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  stream_mux_rr_if.slave            bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int PAD_W = 1 << SEL_W;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [PAD_W-1:0]  valid_pad;
  logic              sel_in_range;
  logic              rr_gnt_vld;
  logic [SEL_W-1:0]  rr_gnt;
  logic [SEL_W-1:0]  scan;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt;
  logic              load_en;
  logic              accept;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [SEL_W-1:0]  out_ch_reg;
  logic              out_last_reg;
  logic [SEL_W-1:0]  rr_ptr_reg;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic              lock_reg;
  logic [SEL_W-1:0]  lock_ch_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]     = bus.in_data[gi*DATA_W +: DATA_W];
      assign bus.in_ready[gi] = accept && (gnt == SEL_W'(gi));
    end
  endgenerate

  // Padding to a power of two lets an out-of-range sel index safely read a zero.
  assign valid_pad    = PAD_W'(bus.in_valid);
  assign sel_in_range = {1'b0, sel} < (SEL_W+1)'(NUM_CH);

  always_comb begin : rr_scan
    rr_gnt_vld = 1'b0;
    rr_gnt     = '0;
    scan       = rr_ptr_reg;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = (scan == SEL_W'(NUM_CH-1)) ? '0 : scan + 1'b1;
      if (!rr_gnt_vld && bus.in_valid[scan]) begin
        rr_gnt_vld = 1'b1;
        rr_gnt     = scan;
      end
    end
  end

  always_comb begin : grant_sel
    gnt_vld = 1'b0;
    gnt     = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_reg) begin
      gnt     = lock_ch_reg;
      gnt_vld = valid_pad[lock_ch_reg];
    end else
`endif
    if (mode) begin
      gnt     = rr_gnt;
      gnt_vld = rr_gnt_vld;
    end else if (sel_in_range) begin
      gnt     = sel;
      gnt_vld = valid_pad[sel];
    end
  end

  assign load_en = !out_valid_reg || bus.out_ready;
  // Gating with rst_n keeps every in_ready low while reset is held.
  assign accept  = rst_n && load_en && gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_last_reg  <= 1'b0;
      rr_ptr_reg    <= SEL_W'(NUM_CH-1);
    end else begin
      if (load_en) out_valid_reg <= accept;
      if (accept) begin
        out_data_reg <= ch_data[gnt];
        out_ch_reg   <= gnt;
        out_last_reg <= bus.in_last[gnt];
        if (mode) rr_ptr_reg <= gnt;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Only lock_ch can be granted while locked, so its last beat is what releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg    <= 1'b0;
      lock_ch_reg <= '0;
    end else if (accept) begin
      lock_reg    <= !bus.in_last[gnt];
      lock_ch_reg <= gnt;
    end
  end
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_stream_mux_rr;
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] ch;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [2:0] sel;
  logic       mode6;
  logic [2:0] sel6;

  int n_pass  = 0;
  int n_total = 0;
  beat_t exp_q[$];

  stream_mux_rr_if #(.NUM_CH(8), .DATA_W(8)) bus ();
  stream_mux_rr_if #(.NUM_CH(6), .DATA_W(8)) bus6 ();

  stream_mux_rr #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus)
  );

  stream_mux_rr #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .bus(bus6)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] c, input logic l);
    beat_t b;
    b.data = d;
    b.ch   = c;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every beat handed to the consumer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got data %0h ch %0d, nothing expected", bus.out_data, bus.out_ch);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", 32'(bus.out_data), 32'(e.data));
        check("beat_ch",   32'(bus.out_ch),   32'(e.ch));
        check("beat_last", 32'(bus.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   b1;
    int   b2;
    logic done;
    logic [7:0] acc;
    int   rr_seq [6];
    rr_seq = '{0, 2, 7, 0, 2, 7};

    // Reset held with every channel requesting
    rst_n = 1'b0; mode = 1'b1; sel = '0; mode6 = 1'b0; sel6 = '0;
    bus.in_valid = 8'hFF; bus.in_last = '0; bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) bus.in_data[k*8 +: 8] = 8'hC0 + 8'(k);
    bus6.in_valid = '0; bus6.in_last = '0; bus6.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) bus6.in_data[k*8 +: 8] = 8'h50 + 8'(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data),  0);
    check("rst_out_ch",    32'(bus.out_ch),    0);
    check("rst_out_last",  32'(bus.out_last),  0);
    check("rst_in_ready",  32'(bus.in_ready),  0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", 32'(bus.in_ready), 32'h01);
    push(8'hC0, 3'd0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = '0;
    @(negedge clk);
    check("first_beat_visible", 32'(bus.out_valid), 1);
    idle(1);

    // Fixed select on ch5
    mode = 1'b0; sel = 3'd5; bus.in_data[5*8 +: 8] = 8'hA5; bus.in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fixed_in_ready", 32'(bus.in_ready), 32'h20);
      push(8'hA5, 3'd5, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = '0;
    idle(2);

    // Asynchronous reset discards a held beat
    sel = 3'd0; bus.in_valid = 8'h01; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = '0;
    @(negedge clk);
    check("hold_before_reset", 32'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_clears", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    idle(1);

    // Round-robin fairness and wrap
    mode = 1'b1; bus.in_valid = 8'b1000_0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_in_ready", 32'(bus.in_ready), 32'(1) << rr_seq[i]);
      push(8'hC0 + 8'(rr_seq[i]), 3'(rr_seq[i]), 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = '0;
    idle(2);

    // Backpressure on ch3
    mode = 1'b0; sel = 3'd3; bus.in_data[3*8 +: 8] = 8'h11; bus.in_valid = 8'h08;
    @(negedge clk);
    check("bp_first_ready", 32'(bus.in_ready), 32'h08);
    push(8'h11, 3'd3, 1'b0);
    @(posedge clk); #1;
    bus.in_data[3*8 +: 8] = 8'h22; bus.out_ready = 1'b0;
    push(8'h22, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_data",  32'(bus.out_data), 32'h11);
      check("bp_hold_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 32'h08);
    @(posedge clk); #1;
    bus.in_valid = '0;
    @(negedge clk);
    check("bp_next_data", 32'(bus.out_data), 32'h22);
    idle(2);

    // Out-of-range select on the 6-channel instance
    mode6 = 1'b0; sel6 = 3'd7; bus6.in_valid = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("oor_in_ready",  32'(bus6.in_ready),  0);
      check("oor_out_valid", 32'(bus6.out_valid), 0);
      @(posedge clk); #1;
    end
    sel6 = 3'd5;
    @(negedge clk);
    check("oor_recover_ready", 32'(bus6.in_ready), 32'h20);
    @(posedge clk); #1;
    bus6.in_valid = '0;
    @(negedge clk);
    check("oor_recover_valid", 32'(bus6.out_valid), 1);
    check("oor_recover_ch",    32'(bus6.out_ch),    5);
    check("oor_recover_data",  32'(bus6.out_data),  32'h55);
    idle(1);

    // Packet stream: ch1 sends 3 beats, ch2 sends two single-beat packets
    mode = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    push(8'h10, 3'd1, 1'b0); push(8'h11, 3'd1, 1'b0); push(8'h12, 3'd1, 1'b1);
    push(8'h20, 3'd2, 1'b1); push(8'h21, 3'd2, 1'b1);
`else
    push(8'h10, 3'd1, 1'b0); push(8'h20, 3'd2, 1'b1); push(8'h11, 3'd1, 1'b0);
    push(8'h21, 3'd2, 1'b1); push(8'h12, 3'd1, 1'b1);
`endif
    b1 = 0; b2 = 0; done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      bus.in_valid = '0;
      bus.in_valid[1] = (b1 < 3);
      bus.in_valid[2] = (b2 < 2);
      bus.in_last[1]  = (b1 == 2);
      bus.in_last[2]  = 1'b1;
      bus.in_data[1*8 +: 8] = 8'h10 + 8'(b1);
      bus.in_data[2*8 +: 8] = 8'h20 + 8'(b2);
      if (b1 == 3 && b2 == 2) done = 1'b1;
      else begin
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        check("pkt_onehot", 32'($onehot0(bus.in_ready)), 1);
        @(posedge clk); #1;
        if (acc[1]) b1++;
        if (acc[2]) b2++;
      end
    end
    check("pkt_done", 32'(done), 1);
    bus.in_valid = '0; bus.in_last = '0;
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every input and on the output.
- Adds a registered output stage and two select modes: fixed (external `sel`) and round-robin fair arbitration.
- Sits between several producer channels (UART/GPIO/sensor sources) and a single shared consumer.

Parameters:
NUM_CH, 8, number of input channels (2..16)
DATA_W, 8, data width per channel in bits (1..64)
SEL_W, $clog2(NUM_CH), width of select and channel-ID fields (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_valid  input  NUM_CH  per-channel valid
in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
in_last  input  NUM_CH  per-channel end-of-packet flag
in_ready  output  NUM_CH  per-channel ready (combinational)
out_valid  output  1  output register holds a beat
out_data  output  DATA_W  registered data
out_ch  output  SEL_W  index of the channel that supplied out_data
out_last  output  1  registered in_last of that beat
out_ready  input  1  consumer ready

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, rr_ptr=NUM_CH-1 (first round-robin grant goes to ch0), lock=0.
- Load enable: load_en = !out_valid || out_ready.
- Grant, fixed mode:
  - grant = sel when in_valid[sel]=1 and sel<NUM_CH; otherwise no grant.
  - An out-of-range sel never grants and never hangs.
- Grant, round-robin mode:
  - grant = the first k with in_valid[k]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - The scan wraps from NUM_CH-1 to 0.
- in_ready[k] = load_en && grant valid && grant==k. At most one bit is set. Never depends on in_valid[k] of other channels except through arbitration.
- Transfer: in_valid[k] && in_ready[k] at a clock edge loads out_data, out_ch=k, out_last=in_last[k], out_valid=1.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Output hold: when out_valid && !out_ready, out_* are held stable and every in_ready is 0.
- Output drain: out_valid && out_ready with no new grant clears out_valid. out_data, out_ch and out_last keep their old values.
- Simultaneous drain and load in one cycle: the new beat replaces the old one, out_valid stays 1, no bubble.
- rr_ptr update: rr_ptr <= grant only on an accepted transfer in round-robin mode. It is unchanged in fixed mode and on idle cycles.
- Mode or sel changes: take effect at the next arbitration. They never alter a beat already held in the output register.
- Reset mid-operation: a held beat is discarded, and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Accepting a beat with in_last=0 sets lock=1 and lock_ch=grant.
  - While lock=1, grant is forced to lock_ch (if in_valid[lock_ch]=1; otherwise no grant) in both modes. sel and round-robin order are ignored.
  - Accepting a beat from lock_ch with in_last=1 clears lock. rr_ptr then updates to lock_ch.
  - Packets are never interleaved.
- Undefined:
  - No lock state exists and arbitration is per beat.
  - in_last is only forwarded to out_last.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0; release rst_n, mode=1 -> first accepted beat is ch0, visible 1 cycle later.
- Fixed mode: mode=0, sel=5, in_valid=8'hFF, ch5 data=8'hA5, out_ready=1 -> only in_ready[5]=1; out_data=8'hA5 and out_ch=5 every cycle.
- Round-robin fairness and wrap: mode=1, in_valid=8'b1000_0101, out_ready=1 -> out_ch sequence 0,2,7,0,2,7; in_ready is one-hot each cycle.
- Backpressure: stream ch3 beats 8'h11, 8'h22; hold out_ready=0 for 4 cycles -> out_data stays 8'h11 and in_ready=0; release -> 8'h22 follows on the next cycle, no beat lost or duplicated.
- Out-of-range select: NUM_CH=6, mode=0, sel=7, in_valid all 1 -> no transfer, out_valid stays 0.
- STREAM_MUX_PKT_LOCK_EN: mode=1, ch1 sends 3 beats (last on 3rd) while ch2 is valid -> out_ch=1,1,1 then 2; without the macro -> out_ch=1,2,1,2,1.
